// File: rtl/vec_mem_pkg.sv
// Shared sizing, vector type and controller state encoding for the vector
// load/store unit.
package vec_mem_pkg;

  localparam int LANES  = 6;
  localparam int LANE_W = 8;
  localparam int DEPTH  = 102;

  typedef logic [LANES-1:0][LANE_W-1:0] vec_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_MERGE,
    ST_RESP
  } state_t;

  // Misaligned, above the 14-bit window, or past the last populated word.
  function automatic logic addr_bad(input logic [31:0] addr, input int depth);
    return (addr[1:0] != 2'b00) || (addr[31:14] != 18'd0) ||
           ({20'd0, addr[13:2]} >= 32'(depth));
  endfunction

endpackage

// File: rtl/lane_merge.sv
// Per-lane select between freshly written store data and the word read back
// from memory; used for read-modify-write of partially masked stores.
module lane_merge #(
  parameter int LANES  = 6,
  parameter int LANE_W = 8
) (
  input  logic [LANES*LANE_W-1:0] i_old,
  input  logic [LANES*LANE_W-1:0] i_new,
  input  logic [LANES-1:0]        i_mask,
  output logic [LANES*LANE_W-1:0] o_merged
);

  always_comb begin
    o_merged = i_old;
    for (int i = 0; i < LANES; i++) begin
      if (i_mask[i]) begin
        o_merged[i*LANE_W +: LANE_W] = i_new[i*LANE_W +: LANE_W];
      end
    end
  end

endmodule

// File: rtl/vec_lsu.sv
// Single-outstanding vector load/store unit: range check, single-cycle
// load/full store, read-modify-write for partially masked stores.
module vec_lsu #(
  parameter int LANES  = vec_mem_pkg::LANES,
  parameter int LANE_W = vec_mem_pkg::LANE_W,
  parameter int DEPTH  = vec_mem_pkg::DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [31:0]             req_addr,
  input  logic [LANES*LANE_W-1:0] req_wdata,
  input  logic [LANES-1:0]        req_mask,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [LANES*LANE_W-1:0] resp_rdata,
  output logic                    resp_err,
  output logic                    mem_we,
  output logic [31:0]             mem_a,
  output logic [LANES*LANE_W-1:0] mem_wd,
  input  logic [LANES*LANE_W-1:0] mem_rd
);

  import vec_mem_pkg::*;

  localparam int VW = LANES * LANE_W;

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_addr;
  logic             r_we;
  logic [VW-1:0]    r_wdata;
  logic [LANES-1:0] r_mask;
  logic [VW-1:0]    r_rdata;
  logic             r_err;

  logic             w_accept;
  logic             w_bad;
  logic             w_partial;
  logic [VW-1:0]    w_merged;

  assign w_accept  = req_valid && (r_state == ST_IDLE);
  assign w_bad     = addr_bad(req_addr, DEPTH);
  assign w_partial = r_we && (r_mask != '0) && (r_mask != '1);

  lane_merge #(
    .LANES  (LANES),
    .LANE_W (LANE_W)
  ) u_lane_merge (
    .i_old    (r_rdata),
    .i_new    (r_wdata),
    .i_mask   (r_mask),
    .o_merged (w_merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_we     = 1'b0;
    mem_a      = '0;
    mem_wd     = '0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_next = w_bad ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_a = r_addr;
        if (!r_we || r_mask == '0) begin
          w_next = ST_RESP;
        end else if (r_mask == '1) begin
          mem_we = 1'b1;
          mem_wd = r_wdata;
          w_next = ST_RESP;
        end else begin
          w_next = ST_MERGE;
        end
      end
      ST_MERGE: begin
        mem_a  = r_addr;
        mem_we = 1'b1;
        mem_wd = w_merged;
        w_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // r_rdata doubles as the read-back buffer for the merge; it is cleared
  // again before RESP so stores always report zero data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_mask  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr  <= req_addr;
        r_we    <= req_we;
        r_wdata <= req_wdata;
        r_mask  <= req_mask;
        r_rdata <= '0;
        r_err   <= w_bad;
      end else if (r_state == ST_ACCESS && (!r_we || w_partial)) begin
        r_rdata <= mem_rd;
      end else if (r_state == ST_MERGE) begin
        r_rdata <= '0;
      end
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_vec_lsu.sv
// Scoreboard bench for vec_lsu: a driver pushes expected responses computed
// from a behavioural word-array model, a monitor pops and compares them.
module tb_vec_lsu;

  import vec_mem_pkg::*;

  localparam int VW = LANES * LANE_W;

  typedef struct {
    logic [VW-1:0] rdata;
    logic          err;
    int            lat;
    int            acc;
    int            hold;
    int            wr;
    logic [31:0]   addr;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_we = 1'b0;
  logic [31:0]      req_addr = '0;
  logic [VW-1:0]    req_wdata = '0;
  logic [LANES-1:0] req_mask = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [VW-1:0]    resp_rdata;
  logic             resp_err;
  logic             mem_we;
  logic [31:0]      mem_a;
  logic [VW-1:0]    mem_wd;
  logic [VW-1:0]    mem_rd;

  logic [VW-1:0]    tb_mem  [DEPTH];
  logic [VW-1:0]    ref_mem [DEPTH];
  logic             poke_en = 1'b0;
  int               poke_idx = 0;
  logic [VW-1:0]    poke_val = '0;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   mon_en  = 1'b0;

  always #5 clk = ~clk;

  vec_lsu dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_mask   (req_mask),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  assign mem_rd = (mem_a[13:2] < DEPTH) ? tb_mem[mem_a[13:2]] : '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (poke_en) tb_mem[poke_idx] <= poke_val;
    else if (mem_we && mem_a[13:2] < DEPTH) tb_mem[mem_a[13:2]] <= mem_wd;
  end

  task automatic chk(input bit ok, input string nm, input logic [VW-1:0] act, input logic [VW-1:0] req);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic poke(input int idx, input logic [VW-1:0] val);
    poke_en  = 1'b1;
    poke_idx = idx;
    poke_val = val;
    ref_mem[idx] = val;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [VW-1:0] wd,
                       input logic [LANES-1:0] mask, input int hold);
    exp_t e;
    int   g;
    int   idx;
    g = 0;
    while (!req_ready) begin
      @(negedge clk);
      g++;
      if (g > 100) begin
        chk(1'b0, "req_ready_timeout", 0, 1);
        return;
      end
    end
    idx     = int'(addr[13:2]);
    e.err   = (addr[1:0] != 2'b00) || (addr[31:14] != 18'd0) || (idx >= DEPTH);
    e.rdata = '0;
    e.wr    = 0;
    e.addr  = addr;
    e.hold  = hold;
    e.acc   = cyc + 1;
    if (e.err) begin
      e.lat = 1;
    end else if (!we) begin
      e.rdata = ref_mem[idx];
      e.lat   = 2;
    end else begin
      e.lat = (mask != '0 && mask != '1) ? 3 : 2;
      e.wr  = (mask != '0) ? 1 : 0;
      for (int l = 0; l < LANES; l++)
        if (mask[l]) ref_mem[idx][l*LANE_W +: LANE_W] = wd[l*LANE_W +: LANE_W];
    end
    sb.push_back(e);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_mask  = mask;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'($urandom());
    req_addr  = $urandom();
    req_wdata = VW'({$urandom(), $urandom()});
    req_mask  = LANES'($urandom());
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk(sb.size() == 0, "drain_timeout", VW'(sb.size()), 0);
  endtask

  // Monitor: holds resp_ready low for the requested number of cycles, checks
  // stability while held, then completes the handshake and compares.
  initial begin
    bit            seen;
    bit            chk_rdy;
    int            held;
    int            wr_cnt;
    logic [VW-1:0] prev_d;
    logic          prev_e;
    seen = 0; chk_rdy = 0; held = 0; wr_cnt = 0; prev_d = '0; prev_e = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        resp_ready = 1'b0;
        seen = 0; chk_rdy = 0; held = 0; wr_cnt = 0;
      end else begin
        if (chk_rdy) begin
          chk(req_ready == 1'b1, "ready_after_handshake", VW'(req_ready), 1);
          chk_rdy = 0;
        end
        if (mem_we) begin
          wr_cnt++;
          if (sb.size() == 0) chk(1'b0, "unexpected_mem_we", VW'(mem_a), 0);
          else chk(mem_a == sb[0].addr, "mem_a_on_write", VW'(mem_a), VW'(sb[0].addr));
        end
        if (!resp_valid) begin
          resp_ready = 1'b0;
        end else if (sb.size() == 0) begin
          chk(1'b0, "unexpected_resp", VW'(resp_valid), 0);
          resp_ready = 1'b1;
        end else begin
          if (!seen) begin
            seen = 1; held = 0;
            chk(cyc - sb[0].acc + 1 == sb[0].lat, "latency", VW'(cyc - sb[0].acc + 1), VW'(sb[0].lat));
          end else begin
            chk(resp_rdata == prev_d && resp_err == prev_e, "resp_stable", resp_rdata, prev_d);
          end
          prev_d = resp_rdata;
          prev_e = resp_err;
          chk(req_ready == 1'b0 && mem_we == 1'b0, "resp_ready_we_low", VW'({req_ready, mem_we}), 0);
          if (held < sb[0].hold) begin
            resp_ready = 1'b0;
            held++;
          end else begin
            resp_ready = 1'b1;
            chk(resp_rdata == sb[0].rdata, "resp_rdata", resp_rdata, sb[0].rdata);
            chk(resp_err == sb[0].err, "resp_err", VW'(resp_err), VW'(sb[0].err));
            chk(wr_cnt == sb[0].wr, "write_count", VW'(wr_cnt), VW'(sb[0].wr));
            void'(sb.pop_front());
            seen = 0; wr_cnt = 0; chk_rdy = 1;
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]      a;
    logic [LANES-1:0] m;
    int               bad_cnt;
    bit               saw;

    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) poke(i, VW'({$urandom(), $urandom()}));
    chk(req_ready == 1'b1 && resp_valid == 1'b0, "reset_handshake", VW'({req_ready, resp_valid}), 2);
    chk(resp_err == 1'b0 && resp_rdata == '0, "reset_resp", resp_rdata, 0);
    chk(mem_we == 1'b0 && mem_a == '0 && mem_wd == '0, "reset_mem", mem_wd | VW'(mem_a), 0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    poke(4, 48'h060504030201);
    issue(1'b0, 32'h10, '0, '0, 0);
    drain();
    issue(1'b1, 32'h08, 48'hAABBCCDDEEFF, 6'b111111, 0);
    issue(1'b0, 32'h08, '0, '0, 0);
    drain();
    chk(ref_mem[2] == 48'hAABBCCDDEEFF, "full_store_word2", tb_mem[2], 48'hAABBCCDDEEFF);
    poke(3, 48'h111111111111);
    issue(1'b1, 32'h0C, 48'h222222222222, 6'b000101, 0);
    drain();
    chk(tb_mem[3] == 48'h111111221122, "merge_word3", tb_mem[3], 48'h111111221122);
    issue(1'b0, 32'h0D, '0, '0, 0);
    issue(1'b0, 32'h198, '0, '0, 0);
    issue(1'b1, 32'h0000_4008, 48'hFFFFFFFFFFFF, 6'b111111, 0);
    issue(1'b0, 32'h10, '0, '0, 5);
    drain();

    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 9))
        0:       a = {18'd0, 12'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
        1:       a = {18'd0, 12'($urandom_range(DEPTH, 4095)), 2'b00};
        2:       a = {18'($urandom_range(1, 262143)), 12'($urandom_range(0, DEPTH - 1)), 2'b00};
        default: a = {18'd0, 12'($urandom_range(0, DEPTH - 1)), 2'b00};
      endcase
      case ($urandom_range(0, 5))
        0:       m = '0;
        1:       m = '1;
        default: m = LANES'($urandom());
      endcase
      issue(1'($urandom()), a, VW'({$urandom(), $urandom()}), m, $urandom_range(0, 3));
    end
    drain();

    // Reset in the merge cycle must drop the write and lose the response.
    mon_en = 1'b0;
    @(negedge clk);
    chk(req_ready == 1'b1, "abort_idle", VW'(req_ready), 1);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'd7 * 4;
    req_wdata = ~ref_mem[7];
    req_mask  = 6'b010010;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk(mem_we == 1'b1, "abort_merge_we", VW'(mem_we), 1);
    rst = 1'b1;
    #1;
    chk(mem_we == 1'b0 && mem_a == '0 && mem_wd == '0, "abort_mem_drop", VW'({mem_we, mem_a}), 0);
    chk(req_ready == 1'b1 && resp_valid == 1'b0, "abort_state", VW'({req_ready, resp_valid}), 2);
    @(negedge clk);
    rst = 1'b0;
    saw = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid) saw = 1;
    end
    chk(!saw, "abort_no_resp", VW'(saw), 0);
    chk(tb_mem[7] == ref_mem[7], "abort_word_kept", tb_mem[7], ref_mem[7]);
    mon_en = 1'b1;
    @(negedge clk);
    issue(1'b0, 32'd7 * 4, '0, '0, 1);
    issue(1'b1, 32'd9 * 4, VW'({$urandom(), $urandom()}), 6'b100001, 0);
    drain();

    bad_cnt = 0;
    for (int i = 0; i < DEPTH; i++) if (tb_mem[i] != ref_mem[i]) bad_cnt++;
    chk(bad_cnt == 0, "mem_final", VW'(bad_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
